// File: rtl/btb_pkg.sv
// Shared BTB constants and the per-set replacement-state record.
// The default geometry is here; the replacement unit re-derives widths from its own parameters.
package btb_pkg;

  localparam int BTB_NUM_SETS = 8;
  localparam int BTB_NUM_WAYS = 4;
  localparam int BTB_IDX_W    = $clog2(BTB_NUM_SETS);
  localparam int BTB_WAY_W    = $clog2(BTB_NUM_WAYS);

  typedef struct packed {
    logic [BTB_NUM_WAYS-2:0] tree;
    logic [BTB_NUM_WAYS-1:0] valid;
  } plru_state_t;

endpackage

// File: rtl/btb_plru_tree.sv
// Combinational tree-PLRU helper for one set: touch a way and search for a victim.
// Node n has children 2n+1 (lower ways) and 2n+2 (higher ways); bit 1 points at the higher half.
module btb_plru_tree #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] tree_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]    way_i,
  output logic [NUM_WAYS-2:0] tree_o,
  output logic [WAY_W-1:0]    victim_o
);

  always_comb begin
    int   node_t;
    logic dir_t;
    tree_o = tree_i;
    node_t = 0;
    dir_t  = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir_t = way_i[WAY_W-1-l];
      for (int k = 0; k < NUM_WAYS-1; k++) begin
        if (k == node_t) tree_o[k] = ~dir_t;
      end
      node_t = 2*node_t + 1 + int'(dir_t);
    end
  end

  // Invalid ways take priority over the tree walk, lowest number first.
  always_comb begin
    int   node_v;
    logic dir_v;
    logic found;
    victim_o = '0;
    node_v   = 0;
    dir_v    = 1'b0;
    found    = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        victim_o = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int l = 0; l < WAY_W; l++) begin
        for (int k = 0; k < NUM_WAYS-1; k++) begin
          if (k == node_v) dir_v = tree_i[k];
        end
        victim_o = (victim_o << 1) | WAY_W'(dir_v);
        node_v   = 2*node_v + 1 + int'(dir_v);
      end
    end
  end

endmodule

// File: rtl/btb_plru.sv
// Tree pseudo-LRU replacement state for the set-associative BTB.
// IF touches are applied first and EX touches on top, so EX wins on shared nodes.
module btb_plru
  import btb_pkg::*;
#(
  parameter int NUM_SETS = BTB_NUM_SETS,
  parameter int NUM_WAYS = BTB_NUM_WAYS,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  input  logic             rd_hit,
  input  logic [WAY_W-1:0] rd_hit_way,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_hit,
  input  logic [WAY_W-1:0] upd_hit_way,
  input  logic             inv_valid,
  input  logic [IDX_W-1:0] inv_index,
  input  logic [WAY_W-1:0] inv_way,
  output logic [WAY_W-1:0] victim_way,
  output logic             set_full
);

  typedef struct packed {
    logic [NUM_WAYS-2:0] tree;
    logic [NUM_WAYS-1:0] valid;
  } set_state_t;

  set_state_t state_q [NUM_SETS];
  set_state_t state_d [NUM_SETS];

  logic [NUM_WAYS-2:0] if_tree;
  logic [NUM_WAYS-2:0] ex_tree_in;
  logic [NUM_WAYS-2:0] ex_tree;
  logic [WAY_W-1:0]    ex_way;
  logic [WAY_W-1:0]    unused_if_victim;
  logic [WAY_W-1:0]    unused_ex_victim;
  logic [NUM_WAYS-2:0] unused_vic_tree;

  btb_plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_if_touch (
    .tree_i   (state_q[rd_index].tree),
    .valid_i  (state_q[rd_index].valid),
    .way_i    (rd_hit_way),
    .tree_o   (if_tree),
    .victim_o (unused_if_victim)
  );

  // EX touches the IF-touched tree when both ports address the same set.
  assign ex_tree_in = (rd_hit && rd_index == upd_index) ? if_tree : state_q[upd_index].tree;
  assign ex_way     = upd_hit ? upd_hit_way : victim_way;

  btb_plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_ex_touch (
    .tree_i   (ex_tree_in),
    .valid_i  (state_q[upd_index].valid),
    .way_i    (ex_way),
    .tree_o   (ex_tree),
    .victim_o (unused_ex_victim)
  );

  btb_plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_victim (
    .tree_i   (state_q[upd_index].tree),
    .valid_i  (state_q[upd_index].valid),
    .way_i    ('0),
    .tree_o   (unused_vic_tree),
    .victim_o (victim_way)
  );

  assign set_full = &state_q[upd_index].valid;

  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      state_d[s] = state_q[s];
      if (rd_hit && rd_index == IDX_W'(s)) state_d[s].tree = if_tree;
      if (inv_valid && inv_index == IDX_W'(s)) state_d[s].valid[inv_way] = 1'b0;
      // Allocation follows the invalidate so a same-way collision leaves the entry valid.
      if (upd_valid && upd_index == IDX_W'(s)) begin
        state_d[s].tree = ex_tree;
        if (!upd_hit) state_d[s].valid[victim_way] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) state_q[s] <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_btb_plru.sv
// Randomised and directed bench for btb_plru against a range-splitting PLRU reference model.
module tb_btb_plru;

  localparam int NS = 8;
  localparam int NW = 4;
  localparam int IW = 3;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] rd_index;
  logic          rd_hit;
  logic [WW-1:0] rd_hit_way;
  logic          upd_valid;
  logic [IW-1:0] upd_index;
  logic          upd_hit;
  logic [WW-1:0] upd_hit_way;
  logic          inv_valid;
  logic [IW-1:0] inv_index;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] victim_way;
  logic          set_full;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: per set, one "victim is in upper half" flag per split, and valid flags.
  int m_tree  [NS][NW-1];
  int m_valid [NS][NW];

  always #5 clk = ~clk;

  btb_plru #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (rd_index),
    .rd_hit      (rd_hit),
    .rd_hit_way  (rd_hit_way),
    .upd_valid   (upd_valid),
    .upd_index   (upd_index),
    .upd_hit     (upd_hit),
    .upd_hit_way (upd_hit_way),
    .inv_valid   (inv_valid),
    .inv_index   (inv_index),
    .inv_way     (inv_way),
    .victim_way  (victim_way),
    .set_full    (set_full)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_victim(input int s);
    int lo, hi, mid, node;
    for (int w = 0; w < NW; w++) if (m_valid[s][w] == 0) return w;
    lo = 0; hi = NW; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_tree[s][node] == 0) begin hi = mid; node = 2*node + 1; end
      else begin lo = mid; node = 2*node + 2; end
    end
    return lo;
  endfunction

  function automatic int m_full(input int s);
    for (int w = 0; w < NW; w++) if (m_valid[s][w] == 0) return 0;
    return 1;
  endfunction

  task automatic m_touch(input int s, input int w);
    int lo, hi, mid, node;
    lo = 0; hi = NW; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_tree[s][node] = 1; hi = mid; node = 2*node + 1; end
      else begin m_tree[s][node] = 0; lo = mid; node = 2*node + 2; end
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < NS; s++) begin
      for (int n = 0; n < NW-1; n++) m_tree[s][n] = 0;
      for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
    end
  endtask

  task automatic m_apply();
    int vic, w;
    if (rst) begin
      m_clear();
      return;
    end
    vic = m_victim(int'(upd_index));
    if (rd_hit) m_touch(int'(rd_index), int'(rd_hit_way));
    if (inv_valid) m_valid[inv_index][inv_way] = 0;
    if (upd_valid) begin
      w = upd_hit ? int'(upd_hit_way) : vic;
      if (!upd_hit) m_valid[upd_index][w] = 1;
      m_touch(int'(upd_index), w);
    end
  endtask

  task automatic idle();
    rst = 1'b0; rd_hit = 1'b0; upd_valid = 1'b0; upd_hit = 1'b0; inv_valid = 1'b0;
    rd_index = '0; rd_hit_way = '0; upd_hit_way = '0; inv_index = '0; inv_way = '0;
  endtask

  // Compare outputs with the model pre-edge, then clock and advance the model.
  task automatic cycle();
    #4;
    check("victim", int'(victim_way), m_victim(int'(upd_index)));
    check("set_full", int'(set_full), m_full(int'(upd_index)));
    @(posedge clk);
    m_apply();
    #1;
  endtask

  task automatic expect_set(input string tag, input int idx, input int vic, input int full);
    idle();
    upd_index = IW'(idx);
    #1;
    check({tag, "_victim"}, int'(victim_way), vic);
    check({tag, "_full"}, int'(set_full), full);
    $display("%s: set %0d victim=%0d full=%0d", tag, idx, victim_way, set_full);
  endtask

  initial begin
    m_clear();
    idle();
    rst = 1'b1;
    upd_index = 3'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_set("reset", 3, 0, 0);

    for (int i = 0; i < 4; i++) begin
      idle();
      upd_valid = 1'b1; upd_index = 3'd3;
      #1;
      check("fill_victim", int'(victim_way), i);
      cycle();
    end
    expect_set("filled", 3, 0, 1);

    idle(); rd_hit = 1'b1; rd_index = 3'd3; rd_hit_way = 2'd0; upd_index = 3'd3;
    cycle();
    expect_set("lru_walk", 3, 2, 1);

    // Bring set 3 back to an all-zero tree: touch way 1, then way 3.
    idle(); rd_hit = 1'b1; rd_index = 3'd3; rd_hit_way = 2'd1; upd_index = 3'd3;
    cycle();
    idle(); upd_valid = 1'b1; upd_hit = 1'b1; upd_index = 3'd3; upd_hit_way = 2'd3;
    cycle();
    idle(); rd_hit = 1'b1; rd_index = 3'd3; rd_hit_way = 2'd1;
    upd_valid = 1'b1; upd_hit = 1'b1; upd_index = 3'd3; upd_hit_way = 2'd2;
    cycle();
    expect_set("simul_touch", 3, 0, 1);

    idle(); inv_valid = 1'b1; inv_index = 3'd3; inv_way = 2'd2; upd_index = 3'd3;
    cycle();
    expect_set("invalidate", 3, 2, 0);

    idle(); inv_valid = 1'b1; inv_index = 3'd3; inv_way = 2'd2;
    upd_valid = 1'b1; upd_index = 3'd3;
    cycle();
    expect_set("inv_alloc", 3, 0, 1);

    idle(); upd_valid = 1'b1; upd_index = 3'd0;
    rd_hit = 1'b1; rd_index = 3'd7; rd_hit_way = 2'd1;
    cycle();
    expect_set("indep_s0", 0, 1, 0);
    expect_set("indep_s7", 7, 0, 0);
    expect_set("indep_s5", 5, 0, 0);
    expect_set("indep_s3", 3, 0, 1);

    idle(); rst = 1'b1; upd_valid = 1'b1; upd_index = 3'd3;
    cycle();
    expect_set("mid_reset_s3", 3, 0, 0);
    expect_set("mid_reset_s0", 0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      logic narrow;
      idle();
      narrow      = ($urandom_range(0, 1) == 1);
      rst         = ($urandom_range(0, 299) == 0);
      rd_hit      = ($urandom_range(0, 1) == 1);
      upd_valid   = ($urandom_range(0, 2) != 0);
      upd_hit     = ($urandom_range(0, 1) == 1);
      inv_valid   = ($urandom_range(0, 3) == 0);
      rd_index    = narrow ? IW'($urandom_range(2, 3)) : IW'($urandom_range(0, NS-1));
      upd_index   = narrow ? IW'($urandom_range(2, 3)) : IW'($urandom_range(0, NS-1));
      inv_index   = narrow ? IW'($urandom_range(2, 3)) : IW'($urandom_range(0, NS-1));
      rd_hit_way  = WW'($urandom_range(0, NW-1));
      upd_hit_way = WW'($urandom_range(0, NW-1));
      inv_way     = WW'($urandom_range(0, NW-1));
      cycle();
    end

    for (int s = 0; s < NS; s++) begin
      expect_set("sweep", s, m_victim(s), m_full(s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
